// File: rtl/zcmt_pkg.sv
// ---------------------------------------------------------------------------
// zcmt_pkg
// Shared types and constants for the ZCMT jump-table fetch path.
//  - zcmt_fetch_state_e : handshake FSM encoding (IDLE, REQ, TAG, WAIT, DRAIN)
//  - jt_cache_entry_t   : one entry of the optional jump-table entry cache
//  - jvt_t              : JVT CSR layout {base, mode}
//  - dcache_req_i_t / dcache_req_o_t : dcache load-port request/response
//  - zcmt_entry_addr()  : table entry address with 32-bit wrap
// ---------------------------------------------------------------------------
package zcmt_pkg;

    localparam int unsigned ZCMT_XLEN        = 32;
    localparam int unsigned ZCMT_ENTRY_BYTES = 4;
    localparam int unsigned ZCMT_INDEX_W     = 8;

    // dcache geometry for a 32-bit core: 12-bit index (page offset) + 20-bit tag
    localparam int unsigned DC_INDEX_W = 12;
    localparam int unsigned DC_TAG_W   = 20;

    typedef enum logic [2:0] {
        ZCMT_IDLE  = 3'd0,
        ZCMT_REQ   = 3'd1,
        ZCMT_TAG   = 3'd2,
        ZCMT_WAIT  = 3'd3,
        ZCMT_DRAIN = 3'd4
    } zcmt_fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [7:0]  index;
        logic [31:0] target;
    } jt_cache_entry_t;

    typedef struct packed {
        logic [ZCMT_XLEN-7:0] base;
        logic [5:0]           mode;
    } jvt_t;

    typedef struct packed {
        logic [DC_INDEX_W-1:0] address_index;
        logic [DC_TAG_W-1:0]   address_tag;
        logic [31:0]           data_wdata;
        logic [0:0]            data_wuser;
        logic                  data_req;
        logic                  data_we;
        logic [3:0]            data_be;
        logic [1:0]            data_size;
        logic [0:0]            data_id;
        logic                  kill_req;
        logic                  tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [0:0]  data_rid;
        logic [31:0] data_rdata;
        logic [0:0]  data_ruser;
    } dcache_req_o_t;

    // {base,6'b0} + index*4; the carry out of bit 31 is intentionally dropped.
    function automatic logic [31:0] zcmt_entry_addr(input logic [ZCMT_XLEN-7:0] base,
                                                    input logic [ZCMT_INDEX_W-1:0] idx);
        return {base, 6'b0} + {22'b0, idx, 2'b0};
    endfunction

endpackage

// File: rtl/zcmt_jt_fetch_if.sv
// ---------------------------------------------------------------------------
// zcmt_jt_fetch_if
// dcache load-port bundle between the jump-table fetch engine and the dcache.
//  req_port_o : request  (fetch engine -> dcache)
//  req_port_i : response (dcache -> fetch engine)
// Modports: master = fetch engine, slave = dcache.
// ---------------------------------------------------------------------------
interface zcmt_jt_fetch_if;
    import zcmt_pkg::*;

    dcache_req_i_t req_port_o;
    dcache_req_o_t req_port_i;

    modport master (output req_port_o, input req_port_i);
    modport slave  (input req_port_o, output req_port_i);

endinterface

// File: rtl/zcmt_jt_cache.sv
// ---------------------------------------------------------------------------
// zcmt_jt_cache
// Small fully associative cache of jump-table entries keyed by the 8-bit
// table index, round-robin replacement. Only built with ZCMT_JT_CACHE_EN.
// Ports:
//  clk_i, rst_ni      clock, asynchronous active-low reset
//  i_lookup_index     index to look up (combinational hit/target)
//  o_hit, o_target    lookup result
//  i_fill_en          write {i_fill_index, i_fill_target} into the RR slot
//  i_inval            clear all entries; wins over a same-cycle fill
// ---------------------------------------------------------------------------
module zcmt_jt_cache
    import zcmt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  i_lookup_index,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_fill_en,
    input  logic [7:0]  i_fill_index,
    input  logic [31:0] i_fill_target,
    input  logic        i_inval
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    jt_cache_entry_t  r_entries [DEPTH];
    logic [PTR_W-1:0] r_rr_ptr;

    always_comb begin
        o_hit    = 1'b0;
        o_target = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entries[i].valid && (r_entries[i].index == i_lookup_index)) begin
                o_hit    = 1'b1;
                o_target = r_entries[i].target;
            end
        end
    end

    // Fills only happen after a lookup miss, so an index is never stored twice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_rr_ptr <= '0;
        end else if (i_inval) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_rr_ptr <= '0;
        end else if (i_fill_en) begin
            r_entries[r_rr_ptr] <= '{valid: 1'b1, index: i_fill_index, target: i_fill_target};
            r_rr_ptr            <= r_rr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/zcmt_jt_fetch.sv
// ---------------------------------------------------------------------------
// zcmt_jt_fetch
// Jump-table entry fetch engine for cm.jt / cm.jalt. Accepts a table index,
// forms jvt.base + index*4, runs one dcache load (req/gnt, index phase,
// tag phase, rvalid) and returns the 32-bit target, or drains the load
// cleanly on a flush.
// Optional feature macro: ZCMT_JT_CACHE_EN (adds the zcmt_jt_cache entry cache).
// Ports:
//  clk_i, rst_ni    clock, asynchronous active-low reset
//  flush_i          abort the fetch in progress
//  fetch_valid_i    request; fetch_index_i held stable until accepted
//  fetch_ready_o    engine idle, request can be accepted
//  fetch_index_i    table index (instr[9:2])
//  jvt_i, jvt_wr_i  JVT CSR value and write strobe
//  entry_valid_o    one-cycle pulse, entry_o valid
//  entry_o          target address read from the table
//  dc               dcache load port (master side)
// ---------------------------------------------------------------------------
module zcmt_jt_fetch
    import zcmt_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned JT_CACHE_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   fetch_valid_i,
    output logic                   fetch_ready_o,
    input  logic [ZCMT_INDEX_W-1:0] fetch_index_i,
    input  jvt_t                   jvt_i,
    input  logic                   jvt_wr_i,
    output logic                   entry_valid_o,
    output logic [31:0]            entry_o,
    zcmt_jt_fetch_if.master        dc
);

    localparam logic [2:0] S_IDLE  = 3'(ZCMT_IDLE);
    localparam logic [2:0] S_REQ   = 3'(ZCMT_REQ);
    localparam logic [2:0] S_TAG   = 3'(ZCMT_TAG);
    localparam logic [2:0] S_WAIT  = 3'(ZCMT_WAIT);
    localparam logic [2:0] S_DRAIN = 3'(ZCMT_DRAIN);

    if (XLEN != 32) begin : g_bad_xlen
        $error("zcmt_jt_fetch: only XLEN == 32 is supported");
    end
    if ((JT_CACHE_DEPTH < 2) || ((JT_CACHE_DEPTH & (JT_CACHE_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("zcmt_jt_fetch: JT_CACHE_DEPTH must be a power of 2 and >= 2");
    end

    logic [2:0]              r_state;
    logic [2:0]              w_state_d;
    logic [31:0]             r_addr_q;
    logic [ZCMT_INDEX_W-1:0] r_index_q;
    logic                    r_kill_pend;
    logic                    r_entry_valid;
    logic [31:0]             r_entry;

    logic [31:0]   w_addr;
    logic          w_accept;
    logic          w_entry_load;
    logic [31:0]   w_entry_d;
    logic          w_fill_en;
    logic          w_kill;
    logic          w_tag_flush;
    logic          w_hit;
    logic [31:0]   w_hit_target;
    dcache_req_i_t w_req;

    logic w_gnt;
    logic w_rvalid;

    assign w_gnt    = dc.req_port_i.data_gnt;
    assign w_rvalid = dc.req_port_i.data_rvalid;
    assign w_addr   = zcmt_entry_addr(jvt_i.base, fetch_index_i);

    // A flush that lands on the grant cycle cannot cancel the request any more;
    // remember it so the tag phase kills the load instead.
    assign w_tag_flush = flush_i | r_kill_pend;

    always_comb begin
        w_state_d    = r_state;
        w_accept     = 1'b0;
        w_entry_load = 1'b0;
        w_entry_d    = dc.req_port_i.data_rdata;
        w_fill_en    = 1'b0;
        w_kill       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_valid_i && !flush_i) begin
                    if (w_hit) begin
                        w_entry_load = 1'b1;
                        w_entry_d    = w_hit_target;
                    end else begin
                        w_accept  = 1'b1;
                        w_state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (w_gnt) begin
                    w_state_d = S_TAG;
                end else if (flush_i) begin
                    w_state_d = S_IDLE;
                end
            end
            S_TAG: begin
                w_kill = w_tag_flush;
                // An early rvalid completes the single outstanding load, so never
                // go on to DRAIN after it (nothing else would ever arrive).
                if (w_rvalid) begin
                    w_entry_load = !w_tag_flush;
                    w_fill_en    = !w_tag_flush;
                    w_state_d    = S_IDLE;
                end else if (w_tag_flush) begin
                    w_state_d = S_DRAIN;
                end else begin
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rvalid) begin
                    w_entry_load = !flush_i;
                    w_fill_en    = !flush_i;
                    w_state_d    = S_IDLE;
                end else if (flush_i) begin
                    w_state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_rvalid) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_addr_q      <= '0;
            r_index_q     <= '0;
            r_kill_pend   <= 1'b0;
            r_entry_valid <= 1'b0;
            r_entry       <= '0;
        end else begin
            r_state       <= w_state_d;
            r_kill_pend   <= (r_state == S_REQ) && w_gnt && flush_i;
            r_entry_valid <= w_entry_load;
            if (w_entry_load) begin
                r_entry <= w_entry_d;
            end
            if (w_accept) begin
                r_addr_q  <= w_addr;
                r_index_q <= fetch_index_i;
            end
        end
    end

    always_comb begin
        w_req               = '0;
        w_req.address_index = r_addr_q[DC_INDEX_W-1:0];
        w_req.address_tag   = r_addr_q[DC_INDEX_W+DC_TAG_W-1:DC_INDEX_W];
        w_req.data_req      = (r_state == S_REQ);
        w_req.data_we       = 1'b0;
        w_req.data_be       = 4'hF;
        w_req.data_size     = 2'b10;
        w_req.data_id       = 1'b1;
        w_req.tag_valid     = (r_state == S_TAG);
        w_req.kill_req      = w_kill;
    end

    assign dc.req_port_o  = w_req;
    assign fetch_ready_o  = (r_state == S_IDLE);
    assign entry_valid_o  = r_entry_valid;
    assign entry_o        = r_entry;

`ifdef ZCMT_JT_CACHE_EN
    logic w_hit_raw;
    logic w_inval;

    // A flush while idle acts as a fence and drops every cached entry.
    assign w_inval = jvt_wr_i | (flush_i & (r_state == S_IDLE));

    zcmt_jt_cache #(
        .DEPTH (JT_CACHE_DEPTH)
    ) u_cache (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_lookup_index (fetch_index_i),
        .o_hit          (w_hit_raw),
        .o_target       (w_hit_target),
        .i_fill_en      (w_fill_en),
        .i_fill_index   (r_index_q),
        .i_fill_target  (dc.req_port_i.data_rdata),
        .i_inval        (w_inval)
    );

    // Entries belong to the old table once the JVT is being rewritten.
    assign w_hit = w_hit_raw & ~jvt_wr_i;

    logic w_unused;
    assign w_unused = ^{jvt_i.mode, dc.req_port_i.data_rid, dc.req_port_i.data_ruser};
`else
    assign w_hit        = 1'b0;
    assign w_hit_target = '0;

    logic w_unused;
    assign w_unused = ^{jvt_i.mode, jvt_wr_i, r_index_q, w_fill_en,
                        dc.req_port_i.data_rid, dc.req_port_i.data_ruser};
`endif

endmodule

// File: tb/tb_zcmt_jt_fetch.sv
// ---------------------------------------------------------------------------
// tb_zcmt_jt_fetch
// Directed bench for zcmt_jt_fetch; the dcache side is driven cycle by cycle.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit
// later. Cache scenario selected by ZCMT_JT_CACHE_EN.
// ---------------------------------------------------------------------------
module tb_zcmt_jt_fetch;
    import zcmt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [7:0]  fetch_index;
    jvt_t        jvt;
    logic        jvt_wr;
    logic        entry_valid;
    logic [31:0] entry;

    int n_checks = 0;
    int n_fail   = 0;

    zcmt_jt_fetch_if dcif ();

    zcmt_jt_fetch #(
        .XLEN           (32),
        .JT_CACHE_DEPTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .fetch_valid_i (fetch_valid),
        .fetch_ready_o (fetch_ready),
        .fetch_index_i (fetch_index),
        .jvt_i         (jvt),
        .jvt_wr_i      (jvt_wr),
        .entry_valid_o (entry_valid),
        .entry_o       (entry),
        .dc            (dcif.master)
    );

    always #5 clk = ~clk;

    logic        dreq, tagv, kill;
    logic [11:0] aidx;
    logic [19:0] atag;
    assign dreq = dcif.req_port_o.data_req;
    assign tagv = dcif.req_port_o.tag_valid;
    assign kill = dcif.req_port_o.kill_req;
    assign aidx = dcif.req_port_o.address_index;
    assign atag = dcif.req_port_o.address_tag;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; fetch_valid = 0; fetch_index = 0; jvt_wr = 0;
        jvt = '0;
        dcif.req_port_i = '0;
        tick(); tick();
        #1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", fetch_ready); end
        n_checks++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evalid got=%b exp=0", entry_valid); end
        n_checks++; if (entry !== 32'h0) begin n_fail++; $display("FAIL reset_entry got=%h exp=0", entry); end
        n_checks++; if ({dreq, tagv, kill} !== 3'b000) begin n_fail++; $display("FAIL reset_req got=%b exp=000", {dreq, tagv, kill}); end
        rst_n = 1'b1;
    endtask

    // base 0x2000>>6, index 5 -> 0x2014; gnt on 3rd REQ cycle, rvalid 3 cycles after gnt
    task automatic test_basic_fetch();
        jvt.base = 26'(32'h2000 >> 6);
        tick(); fetch_valid = 1; fetch_index = 8'd5; #1;
        n_checks++; if (dreq !== 1'b0) begin n_fail++; $display("FAIL basic_idle_req got=%b exp=0", dreq); end
        tick(); fetch_valid = 0; #1;
        n_checks++; if ({dreq, fetch_ready} !== 2'b10) begin n_fail++; $display("FAIL basic_req1 got=%b exp=10", {dreq, fetch_ready}); end
        n_checks++; if (aidx !== 12'h014) begin n_fail++; $display("FAIL basic_aidx got=%h exp=014", aidx); end
        n_checks++; if ({dcif.req_port_o.data_we, dcif.req_port_o.data_be, dcif.req_port_o.data_size, dcif.req_port_o.data_id} !== 8'b0_1111_10_1) begin
            n_fail++; $display("FAIL basic_fixed got=%b exp=01111101",
                {dcif.req_port_o.data_we, dcif.req_port_o.data_be, dcif.req_port_o.data_size, dcif.req_port_o.data_id}); end
        tick(); #1;
        n_checks++; if (dreq !== 1'b1) begin n_fail++; $display("FAIL basic_req2 got=%b exp=1", dreq); end
        tick(); dcif.req_port_i.data_gnt = 1; #1;
        n_checks++; if (dreq !== 1'b1) begin n_fail++; $display("FAIL basic_req3 got=%b exp=1", dreq); end
        tick(); dcif.req_port_i.data_gnt = 0; #1;
        n_checks++; if ({tagv, dreq, kill} !== 3'b100) begin n_fail++; $display("FAIL basic_tag got=%b exp=100", {tagv, dreq, kill}); end
        n_checks++; if (atag !== 20'h00002) begin n_fail++; $display("FAIL basic_atag got=%h exp=00002", atag); end
        tick(); #1;
        n_checks++; if ({tagv, fetch_ready} !== 2'b00) begin n_fail++; $display("FAIL basic_wait got=%b exp=00", {tagv, fetch_ready}); end
        tick(); dcif.req_port_i.data_rvalid = 1; dcif.req_port_i.data_rdata = 32'h8000_0120; #1;
        n_checks++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_ev got=%b exp=0", entry_valid); end
        tick(); dcif.req_port_i.data_rvalid = 0; #1;
        n_checks++; if (entry_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ev got=%b exp=1", entry_valid); end
        n_checks++; if (entry !== 32'h8000_0120) begin n_fail++; $display("FAIL basic_entry got=%h exp=80000120", entry); end
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%b exp=1", fetch_ready); end
        tick(); #1;
        n_checks++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got=%b exp=0", entry_valid); end
    endtask

    task automatic test_flush_wait();
        tick(); fetch_valid = 1; fetch_index = 8'd1; #1;
        tick(); fetch_valid = 0; dcif.req_port_i.data_gnt = 1; #1;
        tick(); dcif.req_port_i.data_gnt = 0; #1;
        tick(); flush = 1; #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fw_wait_ready got=%b exp=0", fetch_ready); end
        tick(); flush = 0; #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fw_drain_ready got=%b exp=0", fetch_ready); end
        tick(); dcif.req_port_i.data_rvalid = 1; dcif.req_port_i.data_rdata = 32'hDEAD_BEEF; #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fw_rv_ready got=%b exp=0", fetch_ready); end
        tick(); dcif.req_port_i.data_rvalid = 0; #1;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fw_back_ready got=%b exp=1", fetch_ready); end
        n_checks++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL fw_ev got=%b exp=0", entry_valid); end
        n_checks++; if (entry !== 32'h8000_0120) begin n_fail++; $display("FAIL fw_entry got=%h exp=80000120", entry); end
    endtask

    task automatic test_flush_tag_req();
        tick(); fetch_valid = 1; fetch_index = 8'd2; #1;
        tick(); fetch_valid = 0; dcif.req_port_i.data_gnt = 1; #1;
        tick(); dcif.req_port_i.data_gnt = 0; flush = 1; #1;
        n_checks++; if ({tagv, kill} !== 2'b11) begin n_fail++; $display("FAIL ft_kill got=%b exp=11", {tagv, kill}); end
        tick(); flush = 0; #1;
        n_checks++; if ({kill, tagv, fetch_ready} !== 3'b000) begin n_fail++; $display("FAIL ft_drain got=%b exp=000", {kill, tagv, fetch_ready}); end
        tick(); dcif.req_port_i.data_rvalid = 1; dcif.req_port_i.data_rdata = 32'h1111_2222; #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL ft_drain2 got=%b exp=0", fetch_ready); end
        tick(); dcif.req_port_i.data_rvalid = 0; #1;
        n_checks++; if ({fetch_ready, entry_valid} !== 2'b10) begin n_fail++; $display("FAIL ft_idle got=%b exp=10", {fetch_ready, entry_valid}); end
        // flush in REQ before gnt
        tick(); fetch_valid = 1; fetch_index = 8'd3; #1;
        tick(); fetch_valid = 0; flush = 1; #1;
        n_checks++; if (dreq !== 1'b1) begin n_fail++; $display("FAIL fr_req got=%b exp=1", dreq); end
        tick(); flush = 0; #1;
        n_checks++; if ({fetch_ready, dreq, tagv} !== 3'b100) begin n_fail++; $display("FAIL fr_idle got=%b exp=100", {fetch_ready, dreq, tagv}); end
        tick(); #1;
        n_checks++; if ({tagv, entry_valid} !== 2'b00) begin n_fail++; $display("FAIL fr_notag got=%b exp=00", {tagv, entry_valid}); end
    endtask

    // base all ones, index 255: 0xFFFFFFC0 + 0x3FC wraps to 0x3BC; best-case latency 4
    task automatic test_addr_wrap();
        jvt.base = {26{1'b1}};
        tick(); fetch_valid = 1; fetch_index = 8'd255; #1;
        tick(); fetch_valid = 0; dcif.req_port_i.data_gnt = 1; #1;
        n_checks++; if ({dreq, aidx} !== {1'b1, 12'h3BC}) begin n_fail++; $display("FAIL wrap_aidx got=%h exp=13bc", {3'b0, dreq, aidx}); end
        tick(); dcif.req_port_i.data_gnt = 0; #1;
        n_checks++; if ({tagv, atag} !== {1'b1, 20'h00000}) begin n_fail++; $display("FAIL wrap_atag got=%h exp=100000", {3'b0, tagv, atag}); end
        tick(); dcif.req_port_i.data_rvalid = 1; dcif.req_port_i.data_rdata = 32'h1234_5678; #1;
        tick(); dcif.req_port_i.data_rvalid = 0; #1;
        n_checks++; if ({entry_valid, entry} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL wrap_entry got=%b/%h exp=1/12345678", entry_valid, entry); end
        jvt.base = 26'(32'h2000 >> 6);
    endtask

    task automatic test_flush_accept_reset();
        tick(); fetch_valid = 1; flush = 1; fetch_index = 8'd4; #1;
        tick(); fetch_valid = 0; flush = 0; #1;
        n_checks++; if ({dreq, fetch_ready} !== 2'b01) begin n_fail++; $display("FAIL fa_noacc got=%b exp=01", {dreq, fetch_ready}); end
        // asynchronous reset while waiting for rvalid
        tick(); fetch_valid = 1; fetch_index = 8'd6; #1;
        tick(); fetch_valid = 0; dcif.req_port_i.data_gnt = 1; #1;
        tick(); dcif.req_port_i.data_gnt = 0; #1;
        tick(); #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready got=%b exp=0", fetch_ready); end
        #2; rst_n = 1'b0; #2;
        n_checks++; if ({fetch_ready, entry_valid, dreq, tagv, kill} !== 5'b10000) begin n_fail++; $display("FAIL rst_async got=%b exp=10000", {fetch_ready, entry_valid, dreq, tagv, kill}); end
        n_checks++; if (entry !== 32'h0) begin n_fail++; $display("FAIL rst_entry got=%h exp=0", entry); end
        tick(); rst_n = 1'b1;
    endtask

    task automatic run_fetch7(input logic [31:0] data);
        tick(); fetch_valid = 1; fetch_index = 8'd7; #1;
        tick(); fetch_valid = 0; dcif.req_port_i.data_gnt = 1; #1;
        tick(); dcif.req_port_i.data_gnt = 0; #1;
        tick(); dcif.req_port_i.data_rvalid = 1; dcif.req_port_i.data_rdata = data; #1;
        tick(); dcif.req_port_i.data_rvalid = 0; #1;
        n_checks++; if ({entry_valid, entry} !== {1'b1, data}) begin n_fail++; $display("FAIL c_fill got=%b/%h exp=1/%h", entry_valid, entry, data); end
    endtask

    task automatic test_cache();
        run_fetch7(32'hCAFE_0007);
        tick(); fetch_valid = 1; fetch_index = 8'd7; #1;
        tick(); fetch_valid = 0; #1;
`ifdef ZCMT_JT_CACHE_EN
        n_checks++; if ({dreq, fetch_ready} !== 2'b01) begin n_fail++; $display("FAIL c_hit_noreq got=%b exp=01", {dreq, fetch_ready}); end
        n_checks++; if ({entry_valid, entry} !== {1'b1, 32'hCAFE_0007}) begin n_fail++; $display("FAIL c_hit got=%b/%h exp=1/cafe0007", entry_valid, entry); end
        tick(); jvt_wr = 1; #1;
        tick(); jvt_wr = 0; fetch_valid = 1; fetch_index = 8'd7; #1;
        tick(); fetch_valid = 0; #1;
        n_checks++; if (dreq !== 1'b1) begin n_fail++; $display("FAIL c_inval_req got=%b exp=1", dreq); end
        tick(); flush = 1; #1;
        tick(); flush = 0; #1;
`else
        n_checks++; if ({dreq, entry_valid} !== 2'b10) begin n_fail++; $display("FAIL nc_refetch got=%b exp=10", {dreq, entry_valid}); end
        tick(); flush = 1; #1;
        tick(); flush = 0; #1;
`endif
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL c_end_ready got=%b exp=1", fetch_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_fetch();
        test_flush_wait();
        test_flush_tag_req();
        test_addr_wrap();
        test_flush_accept_reset();
        test_cache();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
